// File: rtl/jtkunio_gfx_arb.sv
// Shares the SDRAM graphics read port among char/scroll/object slots, each a one-entry cache; misses cost 3+ cycles, hits none.
// JTKUNIO_ARB_RR_EN selects round-robin grant; otherwise fixed priority obj > scr > char.
module jtkunio_gfx_arb #(
   parameter logic [21:0] CHAR_OFFSET = 22'h00000,
   parameter logic [21:0] SCR_OFFSET  = 22'h04000,
   parameter logic [21:0] OBJ_OFFSET  = 22'h24000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        char_cs,
   input  logic [13:0] char_addr,
   output logic [31:0] char_data,
   output logic        char_ok,
   input  logic        scr_cs,
   input  logic [16:0] scr_addr,
   output logic [31:0] scr_data,
   output logic        scr_ok,
   input  logic        obj_cs,
   input  logic [17:0] obj_addr,
   output logic [31:0] obj_data,
   output logic        obj_ok,
   output logic [21:0] sdram_addr,
   output logic        sdram_rd,
   input  logic        sdram_ack,
   input  logic        sdram_dst,
   input  logic [31:0] sdram_dout,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

   state_t           r_state, w_state_nxt;
   logic [2:0][17:0] r_last_addr;
   logic [2:0][31:0] r_last_data;
   logic [2:0]       r_valid;
   logic [17:0]      r_req_addr;
   logic [1:0]       r_gnt;
   logic [21:0]      r_sdram_addr;
   logic             r_sdram_rd;

   logic [2:0][17:0] w_addr;
   logic [2:0]       w_cs, w_ok, w_pend;
   logic             w_gnt_vld;
   logic [1:0]       w_gnt;
   logic [21:0]      w_offset;

   // slot index: 0 = char, 1 = scr, 2 = obj
   assign w_cs   = {obj_cs, scr_cs, char_cs};
   assign w_addr = {obj_addr, {1'b0, scr_addr}, {4'd0, char_addr}};

   always_comb begin
      w_ok = '0;
      for (int i = 0; i < 3; i++)
         w_ok[i] = w_cs[i] & r_valid[i] & (w_addr[i] == r_last_addr[i]);
   end

   assign w_pend = w_cs & ~w_ok;

`ifdef JTKUNIO_ARB_RR_EN
   logic [1:0] r_ptr;
   logic [1:0] w_s1, w_s2;

   function automatic logic [1:0] nxt_slot(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   assign w_s1 = nxt_slot(r_ptr);
   assign w_s2 = nxt_slot(w_s1);

   always_comb begin
      w_gnt_vld = 1'b1;
      w_gnt     = r_ptr;
      if (w_pend[w_s1])       w_gnt = w_s1;
      else if (w_pend[w_s2])  w_gnt = w_s2;
      else if (!w_pend[r_ptr]) w_gnt_vld = 1'b0;
   end

   // reset points at obj so that char is first in line
   always_ff @(posedge clk) begin
      if (!rst_n)                           r_ptr <= 2'd2;
      else if (r_state == IDLE && w_gnt_vld) r_ptr <= w_gnt;
   end
`else
   always_comb begin
      w_gnt_vld = |w_pend;
      w_gnt     = 2'd0;
      if (w_pend[2])      w_gnt = 2'd2;
      else if (w_pend[1]) w_gnt = 2'd1;
   end
`endif

   always_comb begin
      case (w_gnt)
         2'd0:    w_offset = CHAR_OFFSET;
         2'd1:    w_offset = SCR_OFFSET;
         default: w_offset = OBJ_OFFSET;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_gnt_vld) w_state_nxt = REQ;
         REQ:     if (sdram_ack) w_state_nxt = WAIT;
         WAIT:    if (sdram_dst) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last_addr  <= '0;
         r_last_data  <= '0;
         r_valid      <= '0;
         r_req_addr   <= '0;
         r_gnt        <= 2'd0;
         r_sdram_addr <= '0;
         r_sdram_rd   <= 1'b0;
      end else begin
         if (r_state == IDLE && w_gnt_vld) begin
            r_gnt        <= w_gnt;
            r_req_addr   <= w_addr[w_gnt];
            r_sdram_addr <= w_offset + {4'd0, w_addr[w_gnt]};
            r_sdram_rd   <= 1'b1;
         end
         if (r_state == REQ && sdram_ack)
            r_sdram_rd <= 1'b0;
         // data lands for the captured address even if the requester moved on
         if (r_state == WAIT && sdram_dst) begin
            r_last_data[r_gnt] <= sdram_dout;
            r_last_addr[r_gnt] <= r_req_addr;
            r_valid[r_gnt]     <= 1'b1;
         end
      end
   end

   assign char_data  = r_last_data[0];
   assign scr_data   = r_last_data[1];
   assign obj_data   = r_last_data[2];
   assign char_ok    = w_ok[0];
   assign scr_ok     = w_ok[1];
   assign obj_ok     = w_ok[2];
   assign sdram_addr = r_sdram_addr;
   assign sdram_rd   = r_sdram_rd;
   assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_jtkunio_gfx_arb.sv
// Bench for jtkunio_gfx_arb: directed scenarios plus randomized traffic against a slot-cache model.
module tb_jtkunio_gfx_arb;
   localparam logic [21:0] COFF = 22'h00000;
   localparam logic [21:0] SOFF = 22'h3F0000;
   localparam logic [21:0] OOFF = 22'h24000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        char_cs, scr_cs, obj_cs;
   logic [13:0] char_addr;
   logic [16:0] scr_addr;
   logic [17:0] obj_addr;
   logic [31:0] char_data, scr_data, obj_data;
   logic        char_ok, scr_ok, obj_ok;
   logic [21:0] sdram_addr;
   logic        sdram_rd, sdram_ack, sdram_dst, busy;
   logic [31:0] sdram_dout;

   int n_cmp = 0;
   int n_err = 0;

   logic [2:0]  m_valid;
   logic [17:0] m_addr [3];
   logic [31:0] m_data [3];
   int          m_ptr;

   jtkunio_gfx_arb #(.CHAR_OFFSET(COFF), .SCR_OFFSET(SOFF), .OBJ_OFFSET(OOFF)) dut (
      .clk(clk), .rst_n(rst_n),
      .char_cs(char_cs), .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
      .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
      .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
      .sdram_addr(sdram_addr), .sdram_rd(sdram_rd), .sdram_ack(sdram_ack),
      .sdram_dst(sdram_dst), .sdram_dout(sdram_dout), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] cur_addr(input int i);
      case (i)
         0:       return {4'd0, char_addr};
         1:       return {1'b0, scr_addr};
         default: return obj_addr;
      endcase
   endfunction

   function automatic logic [21:0] exp_sdram(input int i);
      logic [21:0] off;
      off = (i == 0) ? COFF : (i == 1) ? SOFF : OOFF;
      return off + {4'd0, cur_addr(i)};
   endfunction

   function automatic logic [2:0] model_ok();
      logic [2:0] cs, ok;
      cs = {obj_cs, scr_cs, char_cs};
      for (int i = 0; i < 3; i++)
         ok[i] = cs[i] && m_valid[i] && (m_addr[i] == cur_addr(i));
      return ok;
   endfunction

   function automatic int pick(input logic [2:0] pend, input int ptr);
`ifdef JTKUNIO_ARB_RR_EN
      for (int k = 1; k <= 3; k++)
         if (pend[(ptr + k) % 3]) return (ptr + k) % 3;
`else
      for (int i = 2; i >= 0; i--)
         if (pend[i]) return i;
`endif
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = '0;
      m_ptr   = 2;
      for (int i = 0; i < 3; i++) begin
         m_addr[i] = '0;
         m_data[i] = '0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; char_cs = 0; scr_cs = 0; obj_cs = 0;
      sdram_ack = 0; sdram_dst = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // plays the SDRAM controller for one read; returns at the negedge after dst, +1
   task automatic serve(input int dly, input logic [31:0] d, output bit got,
                        output logic [21:0] a, output bit stable, output logic [2:0] ok_pre);
      got = 0; stable = 1; a = '0; ok_pre = '0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (sdram_rd) got = 1;
      end
      if (!got) return;
      a = sdram_addr;
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         if (!sdram_rd || sdram_addr !== a) stable = 0;
      end
      sdram_ack = 1;
      @(negedge clk);
      sdram_ack = 0;
      ok_pre = {obj_ok, scr_ok, char_ok};
      sdram_dst = 1; sdram_dout = d;
      @(negedge clk);
      sdram_dst = 0;
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 0; sdram_ack = 0; sdram_dst = 0; sdram_dout = '0;
      char_cs = 0; scr_cs = 0; obj_cs = 0;
      char_addr = '0; scr_addr = '0; obj_addr = '0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (sdram_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %b expected 0", sdram_rd); end
      n_cmp++; if (sdram_addr !== 22'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 0", sdram_addr); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      char_cs = 1; scr_cs = 1; obj_cs = 1;
      #1;
      n_cmp++; if ({obj_ok, scr_ok, char_ok} !== 3'b000) begin n_err++; $display("FAIL reset_ok: got %b expected 000", {obj_ok, scr_ok, char_ok}); end
      n_cmp++; if ({obj_data, scr_data, char_data} !== 96'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", {obj_data, scr_data, char_data}); end
      char_cs = 0; scr_cs = 0; obj_cs = 0;
      @(negedge clk);
      rst_n = 1;
      model_reset();
   endtask

   task automatic test_char_miss_hit();
      bit got, st; logic [21:0] a; logic [2:0] okp;
      char_addr = 14'h0010; char_cs = 1;
      serve(0, 32'hDEADBEEF, got, a, st, okp);
      n_cmp++; if (!got) begin n_err++; $display("FAIL char_rd: got no sdram_rd expected a request"); end
      n_cmp++; if (a !== 22'h00010) begin n_err++; $display("FAIL char_addr: got %h expected 000010", a); end
      n_cmp++; if (okp[0] !== 1'b0) begin n_err++; $display("FAIL char_ok_early: got %b expected 0", okp[0]); end
      n_cmp++; if (char_ok !== 1'b1) begin n_err++; $display("FAIL char_ok: got %b expected 1", char_ok); end
      n_cmp++; if (char_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL char_data: got %h expected deadbeef", char_data); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         n_cmp++; if (sdram_rd !== 1'b0 || char_ok !== 1'b1) begin n_err++; $display("FAIL char_hit: got rd=%b ok=%b expected rd=0 ok=1", sdram_rd, char_ok); end
      end
      char_cs = 0;
   endtask

   task automatic test_wrap();
      bit got, st; logic [21:0] a; logic [2:0] okp;
      scr_addr = 17'h1FFFF; scr_cs = 1;
      serve(1, 32'h5C0F_F00D, got, a, st, okp);
      n_cmp++; if (a !== 22'h00FFFF) begin n_err++; $display("FAIL scr_wrap_addr: got %h expected 00ffff", a); end
      n_cmp++; if (scr_ok !== 1'b1 || scr_data !== 32'h5C0F_F00D) begin n_err++; $display("FAIL scr_wrap_data: got ok=%b %h expected ok=1 5c0ff00d", scr_ok, scr_data); end
      scr_cs = 0;
   endtask

   task automatic test_priority();
      bit got, st; logic [21:0] a; logic [2:0] okp, pend; int g;
      do_reset();
      @(negedge clk);
      char_addr = 14'h0123; scr_addr = 17'h00456; obj_addr = 18'h00789;
      char_cs = 1; scr_cs = 1; obj_cs = 1;
      for (int n = 0; n < 3; n++) begin
         #1;
         pend = {obj_cs, scr_cs, char_cs} & ~model_ok();
         g = pick(pend, m_ptr);
         serve(0, 32'hA000_0000 + 32'(n), got, a, st, okp);
         n_cmp++; if (g < 0 || a !== exp_sdram(g)) begin n_err++; $display("FAIL prio_order%0d: got %h expected %h", n, a, (g < 0) ? 22'h0 : exp_sdram(g)); end
         n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL prio_idle_gap%0d: got busy=%b expected 0", n, busy); end
         if (g >= 0) begin
            m_valid[g] = 1; m_addr[g] = cur_addr(g); m_data[g] = 32'hA000_0000 + 32'(n); m_ptr = g;
         end
      end
      n_cmp++; if ({obj_ok, scr_ok, char_ok} !== 3'b111) begin n_err++; $display("FAIL prio_all_ok: got %b expected 111", {obj_ok, scr_ok, char_ok}); end
      char_cs = 0; scr_cs = 0; obj_cs = 0;
   endtask

   task automatic test_addr_change();
      bit got, st; logic [21:0] a; logic [2:0] okp;
      do_reset();
      @(negedge clk);
      obj_addr = 18'h100; obj_cs = 1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (sdram_rd) got = 1;
      end
      n_cmp++; if (!got || sdram_addr !== 22'h24100) begin n_err++; $display("FAIL chg_first_addr: got %h expected 024100", sdram_addr); end
      sdram_ack = 1;
      @(negedge clk);
      sdram_ack = 0; obj_addr = 18'h200;
      sdram_dst = 1; sdram_dout = 32'h1111_0100;
      @(negedge clk);
      sdram_dst = 0;
      #1;
      n_cmp++; if (obj_ok !== 1'b0 || obj_data !== 32'h1111_0100) begin n_err++; $display("FAIL chg_stale: got ok=%b %h expected ok=0 11110100", obj_ok, obj_data); end
      serve(0, 32'h2222_0200, got, a, st, okp);
      n_cmp++; if (a !== 22'h24200) begin n_err++; $display("FAIL chg_second_addr: got %h expected 024200", a); end
      n_cmp++; if (obj_ok !== 1'b1 || obj_data !== 32'h2222_0200) begin n_err++; $display("FAIL chg_second_data: got ok=%b %h expected ok=1 22220200", obj_ok, obj_data); end
      obj_cs = 0;
   endtask

   task automatic test_reset_mid();
      bit got;
      do_reset();
      @(negedge clk);
      char_addr = 14'h0055; char_cs = 1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (sdram_rd) got = 1;
      end
      n_cmp++; if (!got) begin n_err++; $display("FAIL rstmid_req: got no sdram_rd expected a request"); end
      rst_n = 0; char_cs = 0;
      @(negedge clk);
      rst_n = 1; sdram_dst = 1; sdram_dout = 32'hBAD0_BAD0;
      @(negedge clk);
      sdram_dst = 0;
      #1;
      n_cmp++; if (sdram_rd !== 1'b0 || busy !== 1'b0 || sdram_addr !== 22'h0) begin n_err++; $display("FAIL rstmid_idle: got rd=%b busy=%b addr=%h expected 0 0 0", sdram_rd, busy, sdram_addr); end
      char_cs = 1;
      #1;
      n_cmp++; if (char_ok !== 1'b0 || char_data !== 32'h0) begin n_err++; $display("FAIL rstmid_dst_ignored: got ok=%b %h expected ok=0 0", char_ok, char_data); end
      char_cs = 0; char_addr = '0; scr_addr = '0; obj_addr = '0; scr_cs = 1; obj_cs = 1; char_cs = 1;
      #1;
      n_cmp++; if ({obj_ok, scr_ok, char_ok} !== 3'b000) begin n_err++; $display("FAIL rstmid_ok: got %b expected 000", {obj_ok, scr_ok, char_ok}); end
      char_cs = 0; scr_cs = 0; obj_cs = 0;
      model_reset();
   endtask

   task automatic test_ack_delay();
      bit got, st; logic [21:0] a; logic [2:0] okp;
      @(negedge clk);
      obj_addr = 18'h3FFFF; obj_cs = 1;
      serve(10, 32'hC0DE_0010, got, a, st, okp);
      n_cmp++; if (a !== 22'h063FFF) begin n_err++; $display("FAIL delay_addr: got %h expected 063fff", a); end
      n_cmp++; if (!st) begin n_err++; $display("FAIL delay_stable: got unstable rd/addr expected stable for 10 cycles"); end
      n_cmp++; if (obj_ok !== 1'b1 || obj_data !== 32'hC0DE_0010) begin n_err++; $display("FAIL delay_data: got ok=%b %h expected ok=1 c0de0010", obj_ok, obj_data); end
      obj_cs = 0;
   endtask

   task automatic test_random();
      bit got, st; logic [21:0] a; logic [2:0] okp, eok, pend; logic [31:0] d; int g;
      do_reset();
      for (int it = 0; it < 60; it++) begin
         @(negedge clk);
         {obj_cs, scr_cs, char_cs} = 3'($urandom_range(0, 7));
         char_addr = 14'($urandom_range(0, 2)) << 4;
         scr_addr  = (17'h1FFFE + 17'($urandom_range(0, 2)));
         obj_addr  = 18'($urandom_range(0, 2)) << 8;
         #1;
         eok = model_ok();
         n_cmp++; if ({obj_ok, scr_ok, char_ok} !== eok) begin n_err++; $display("FAIL rnd_ok%0d: got %b expected %b", it, {obj_ok, scr_ok, char_ok}, eok); end
         n_cmp++; if ({obj_data, scr_data, char_data} !== {m_data[2], m_data[1], m_data[0]}) begin n_err++; $display("FAIL rnd_data%0d: got %h expected %h", it, {obj_data, scr_data, char_data}, {m_data[2], m_data[1], m_data[0]}); end
         pend = {obj_cs, scr_cs, char_cs} & ~eok;
         g = pick(pend, m_ptr);
         if (g < 0) begin
            @(negedge clk);
            n_cmp++; if (sdram_rd !== 1'b0) begin n_err++; $display("FAIL rnd_spurious%0d: got rd=%b expected 0", it, sdram_rd); end
         end else begin
            d = $urandom;
            serve($urandom_range(0, 3), d, got, a, st, okp);
            n_cmp++; if (!got || a !== exp_sdram(g)) begin n_err++; $display("FAIL rnd_addr%0d: got %h expected %h", it, a, exp_sdram(g)); end
            n_cmp++; if (!st || okp[g] !== 1'b0) begin n_err++; $display("FAIL rnd_hold%0d: got stable=%b ok_pre=%b expected 1 0", it, st, okp[g]); end
            m_valid[g] = 1; m_addr[g] = cur_addr(g); m_data[g] = d; m_ptr = g;
            eok = model_ok();
            n_cmp++; if ({obj_ok, scr_ok, char_ok} !== eok || {obj_data, scr_data, char_data} !== {m_data[2], m_data[1], m_data[0]}) begin n_err++; $display("FAIL rnd_fill%0d: got ok=%b expected %b", it, {obj_ok, scr_ok, char_ok}, eok); end
         end
         char_cs = 0; scr_cs = 0; obj_cs = 0;
      end
   endtask

   initial begin
      rst_n = 0; sdram_ack = 0; sdram_dst = 0; sdram_dout = '0;
      char_cs = 0; scr_cs = 0; obj_cs = 0;
      char_addr = '0; scr_addr = '0; obj_addr = '0;
      model_reset();
      test_reset();
      test_char_miss_hit();
      test_wrap();
      test_priority();
      test_addr_change();
      test_reset_mid();
      test_ack_delay();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/jtkunio_gfx_arb.md
# jtkunio_gfx_arb

Shares the single SDRAM graphics read port among the three Kunio video fetchers: char, scroll and object. Each fetcher sees a private ROM slot with a one-entry cache; the arbiter turns misses into SDRAM read transactions and returns the 32-bit word to the owning slot. It sits between `jtkunio_video` and the SDRAM controller in the game top level.

## Interface
Parameters:
- `CHAR_OFFSET`, 22'h00000, SDRAM word base of the char region
- `SCR_OFFSET`, 22'h04000, SDRAM word base of the scroll region
- `OBJ_OFFSET`, 22'h24000, SDRAM word base of the object region

Ports:
- `clk` in 1: system clock; the only clock
- `rst_n` in 1: reset, synchronous, active-low
- `char_cs` in 1: char fetch request
- `char_addr` in 14: char word address
- `char_data` out 32: char word
- `char_ok` out 1: `char_data` valid for current `char_addr`
- `scr_cs` in 1, `scr_addr` in 17, `scr_data` out 32, `scr_ok` out 1: same for scroll
- `obj_cs` in 1, `obj_addr` in 18, `obj_data` out 32, `obj_ok` out 1: same for objects
- `sdram_addr` out 22: SDRAM word address
- `sdram_rd` out 1: read request, held until acked
- `sdram_ack` in 1: one-cycle pulse, request accepted
- `sdram_dst` in 1: one-cycle pulse, `sdram_dout` valid
- `sdram_dout` in 32: read data
- `busy` out 1: transaction in flight (state ≠ IDLE)

## Operation
- Each slot holds `last_addr`, `last_data`, `valid`. `x_ok = x_cs & valid & (x_addr == last_addr)`, combinational from registers and live inputs; `x_data = last_data` always.
- Slot is pending when `x_cs & ~x_ok`.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: if any slot pending, grant one (see Configuration), register grant, `sdram_addr = OFFSET + zero-extended x_addr`, capture that address as `req_addr`, assert `sdram_rd`, go REQ.
  - REQ: hold `sdram_rd`/`sdram_addr` stable; on `sdram_ack` drop `sdram_rd`, go WAIT.
  - WAIT: on `sdram_dst` write `last_data = sdram_dout`, `last_addr = req_addr`, `valid = 1` into granted slot; go IDLE.
- Address add is 22-bit modulo; no overflow detection.
- Requester changes address mid-flight: transaction completes and stores data for `req_addr`; ok stays low since compare fails; slot is pending again in IDLE.
- `x_cs` dropped mid-flight: transaction completes and updates slot; no abort.
- `sdram_dst` in IDLE or REQ, `sdram_ack` in IDLE or WAIT: ignored.
- `sdram_ack` and `sdram_dst` same cycle in REQ: ack honoured, dst ignored (controller must not do this).
- Reset (any state): state IDLE, `sdram_rd=0`, `sdram_addr=0`, all `valid=0` (all ok low), `last_addr=0`, `last_data=0`, RR pointer = obj (so char wins first), `busy=0`. Reset mid-transaction abandons it; late `dst` ignored.

## Timing
- Miss seen at cycle N (IDLE) → `sdram_rd` high at N+1.
- Ack at N+1 → WAIT at N+2; dst at N+2 → slot written at edge ending N+2; `x_ok` high at N+3. Minimum miss latency 3 cycles.
- Back-to-back: next grant evaluated in IDLE the cycle after dst; one idle cycle between transactions.
- Hit: `x_ok` follows `x_addr` in the same cycle, zero latency.

## Configuration
- `JTKUNIO_ARB_RR_EN` defined: round-robin. Pointer holds last granted slot; next grant is first pending slot after it in order char→scr→obj→char; pointer updates on grant.
- Undefined: fixed priority obj > scr > char; pointer unused.

## Test plan
- Reset then `char_cs=1, char_addr=14'h0010`, ack same cycle as rd, dst next cycle with `32'hDEADBEEF` → `sdram_addr=22'h00010`, `char_ok=1` three cycles after request, `char_data=32'hDEADBEEF`; repeat same address → ok immediate, no `sdram_rd`.
- `scr_addr=17'h1FFFF` with `SCR_OFFSET=22'h3F0000` → `sdram_addr=22'h00FFFF` (wrap).
- All three pending after reset: RR build grants char, scr, obj in that order; fixed build grants obj, scr, char.
- `obj_addr` changes from 18'h100 to 18'h200 while in WAIT → first dst stores 18'h100 data, `obj_ok` stays low, second request issued at 22'h24200, ok high after its dst.
- `rst_n=0` for one cycle during REQ, then dst pulse → `sdram_rd=0`, all ok low, dst ignored, `busy=0`.
- Ack delayed 10 cycles → `sdram_rd` and `sdram_addr` stable for all 10 cycles.
